// File: rtl/arb_pkg.sv
// Shared types and defaults for the weighted round-robin arbiter.
// The FSM state enum, the weight storage type and a one-hot helper live here.
package arb_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int WGT_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  typedef logic [WGT_W_DEF-1:0] wgt_t;
  typedef wgt_t weight_arr_t [NREQ_DEF];

  function automatic logic [NREQ_DEF-1:0] onehot4(input logic [1:0] id);
    logic [NREQ_DEF-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: the search starts one past last_id
// and wraps, so last_id itself has the lowest priority.
module rr_pick (
  input  logic [3:0] req,
  input  logic [1:0] last_id,
  output logic       valid,
  output logic [1:0] id
);

  logic [1:0] idx;

  // Scan from the lowest priority upward so the highest-priority hit is written last.
  always_comb begin
    valid = 1'b0;
    id    = last_id;
    idx   = last_id;
    for (int k = 4; k >= 1; k--) begin
      idx = last_id + 2'(k);
      if (req[idx]) begin
        valid = 1'b1;
        id    = idx;
      end
    end
  end

endmodule

// File: rtl/wrr_arbiter_ctrl.sv
// Weighted round-robin arbiter: a grantee holds the resource for up to
// weight[id] transfers, followed by a single turnaround cycle.
module wrr_arbiter_ctrl
  import arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WGT_W = WGT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             xfer_done,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_idx,
  input  logic [WGT_W-1:0] cfg_wgt,
  output logic [NREQ-1:0]  gnt,
  output logic [1:0]       gnt_id,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [1:0]       gnt_id_q, gnt_id_d;
  logic [1:0]       last_id_q, last_id_d;
  logic [WGT_W-1:0] credit_q, credit_d;
  logic             busy_q, busy_d;
  logic [WGT_W-1:0] weight_q [NREQ];
  logic [WGT_W-1:0] weight_d [NREQ];

  logic             pick_valid;
  logic [1:0]       pick_id;
  logic [WGT_W-1:0] load_wgt;

  rr_pick u_pick (
    .req     (req),
    .last_id (last_id_q),
    .valid   (pick_valid),
    .id      (pick_id)
  );

  // Credit loads always read the registered weight, so a same-cycle write lands later.
  assign load_wgt = weight_q[pick_id];

  always_comb begin
    weight_d = weight_q;
    if (cfg_we) begin
      weight_d[cfg_idx] = cfg_wgt;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_id_d  = gnt_id_q;
    last_id_d = last_id_q;
    credit_d  = credit_q;
    unique case (state_q)
      IDLE, GAP: begin
        if (pick_valid) begin
          state_d   = GRANT;
          gnt_id_d  = pick_id;
          last_id_d = pick_id;
          credit_d  = (load_wgt == '0) ? WGT_W'(1) : load_wgt;
        end else if (state_q == GAP) begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (xfer_done) begin
          // At credit 1 the counter holds; the release itself ends the grant.
          if (credit_q <= WGT_W'(1)) begin
            state_d = GAP;
          end else begin
            credit_d = credit_q - WGT_W'(1);
            if (!req[gnt_id_q]) begin
              state_d = GAP;
            end
          end
        end else if (!req[gnt_id_q]) begin
          state_d = GAP;
        end
      end
      default: state_d = IDLE;
    endcase

    gnt_d  = (state_d == GRANT) ? onehot4(gnt_id_d) : '0;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= 2'd0;
      last_id_q <= 2'd3;
      credit_q  <= '0;
      busy_q    <= 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        weight_q[i] <= WGT_W'(1);
      end
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      last_id_q <= last_id_d;
      credit_q  <= credit_d;
      busy_q    <= busy_d;
      weight_q  <= weight_d;
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_wrr_arbiter_ctrl.sv
// Directed self-checking bench for wrr_arbiter_ctrl; one task per scenario.
module tb_wrr_arbiter_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       xfer_done;
  logic       cfg_we;
  logic [1:0] cfg_idx;
  logic [3:0] cfg_wgt;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;

  int checks;
  int failures;

  wrr_arbiter_ctrl #(.NREQ(4), .WGT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .xfer_done (xfer_done),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_wgt   (cfg_wgt),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    checks++;
    if (gnt_id !== 2'd0) begin failures++; $display("FAIL reset_gnt_id got=%0d exp=0", gnt_id); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    $display("test_reset: gnt=%b gnt_id=%0d busy=%b", gnt, gnt_id, busy);
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_ids [5];
    logic [3:0] exp_gnt;
    exp_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    req = 4'b1111;
    tick();
    for (int n = 0; n < 5; n++) begin
      exp_gnt = 4'b0001 << exp_ids[n];
      checks++;
      if (gnt !== exp_gnt || gnt_id !== exp_ids[n] || busy !== 1'b1) begin
        failures++;
        $display("FAIL rr_grant%0d got gnt=%b id=%0d busy=%b exp gnt=%b id=%0d busy=1",
                 n, gnt, gnt_id, busy, exp_gnt, exp_ids[n]);
      end
      xfer_done = 1'b1;
      tick();
      xfer_done = 1'b0;
      checks++;
      if (gnt !== 4'b0000 || busy !== 1'b1) begin
        failures++;
        $display("FAIL rr_gap%0d got gnt=%b busy=%b exp gnt=0000 busy=1", n, gnt, busy);
      end
      $display("test_round_robin: grant %0d to id %0d", n, exp_ids[n]);
      if (n < 4) tick();
    end
    req = 4'b0000;
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rr_idle busy got=%b exp=0", busy); end
  endtask

  task automatic test_weighted();
    logic [3:0] exp_seq [12];
    exp_seq = '{4'b0001, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000,
                4'b0001, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
    do_reset();
    cfg_we = 1'b1; cfg_idx = 2'd2; cfg_wgt = 4'd3;
    tick();
    cfg_idx = 2'd0; cfg_wgt = 4'd1;
    tick();
    cfg_we = 1'b0;
    req = 4'b0101;
    xfer_done = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++;
      if (gnt !== exp_seq[c]) begin
        failures++;
        $display("FAIL wrr_cycle%0d got gnt=%b exp=%b", c, gnt, exp_seq[c]);
      end
      $display("test_weighted: cycle %0d gnt=%b", c, gnt);
    end
    req = 4'b0000;
    xfer_done = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL wrr_idle busy got=%b exp=0", busy); end
  endtask

  task automatic test_abandon();
    req = 4'b0010;
    tick();
    req = 4'b0000;
    checks++;
    if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
      failures++;
      $display("FAIL abandon_grant got gnt=%b id=%0d exp gnt=0010 id=1", gnt, gnt_id);
    end
    tick();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b1) begin
      failures++;
      $display("FAIL abandon_gap got gnt=%b busy=%b exp gnt=0000 busy=1", gnt, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL abandon_idle busy got=%b exp=0", busy); end
    $display("test_abandon: single-cycle request abandoned");
  endtask

  task automatic test_zero_weight();
    cfg_we = 1'b1; cfg_idx = 2'd1; cfg_wgt = 4'd0;
    tick();
    cfg_we = 1'b0;
    req = 4'b0010;
    tick();
    checks++;
    if (gnt !== 4'b0010) begin failures++; $display("FAIL zw_grant got gnt=%b exp=0010", gnt); end
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    checks++;
    if (gnt !== 4'b0000) begin failures++; $display("FAIL zw_release got gnt=%b exp=0000", gnt); end
    req = 4'b0000;
    tick();
    $display("test_zero_weight: weight 0 acts as 1");
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_wgt = 4'd3;
    tick();
    cfg_we = 1'b0;
    req = 4'b0100;
    tick();
    checks++;
    if (gnt !== 4'b0100) begin failures++; $display("FAIL rstmid_grant got gnt=%b exp=0100", gnt); end
    rst = 1'b1;
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_wgt = 4'd7;
    tick();
    rst = 1'b0;
    cfg_we = 1'b0;
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_drop got gnt=%b busy=%b exp gnt=0000 busy=0", gnt, busy);
    end
    req = 4'b1111;
    tick();
    checks++;
    if (gnt !== 4'b0001) begin failures++; $display("FAIL rstmid_first got gnt=%b exp=0001", gnt); end
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0;
    checks++;
    if (gnt !== 4'b0000) begin failures++; $display("FAIL rstmid_weight got gnt=%b exp=0000", gnt); end
    req = 4'b0000;
    tick();
    $display("test_reset_mid_grant: reset dropped grant and restored weights");
  endtask

  task automatic test_cfg_active();
    do_reset();
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_wgt = 4'd2;
    tick();
    cfg_we = 1'b0;
    req = 4'b0001;
    tick();
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_wgt = 4'd5;
    tick();
    cfg_we = 1'b0;
    checks++;
    if (gnt !== 4'b0001) begin failures++; $display("FAIL cfgact_hold got gnt=%b exp=0001", gnt); end
    xfer_done = 1'b1;
    tick();
    checks++;
    if (gnt !== 4'b0001) begin failures++; $display("FAIL cfgact_xfer1 got gnt=%b exp=0001", gnt); end
    tick();
    checks++;
    if (gnt !== 4'b0000) begin failures++; $display("FAIL cfgact_release got gnt=%b exp=0000", gnt); end
    xfer_done = 1'b0;
    tick();
    xfer_done = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      tick();
      checks++;
      if (gnt !== ((t < 5) ? 4'b0001 : 4'b0000)) begin
        failures++;
        $display("FAIL cfgact_new_xfer%0d got gnt=%b exp=%b", t, gnt, (t < 5) ? 4'b0001 : 4'b0000);
      end
    end
    xfer_done = 1'b0;
    req = 4'b0000;
    tick();
    $display("test_cfg_active: running credit kept, new weight 5 on next grant");
  endtask

  task automatic test_load_cycle_write();
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_wgt = 4'd1;
    req = 4'b0001;
    tick();
    cfg_we = 1'b0;
    xfer_done = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      tick();
      checks++;
      if (gnt !== ((t < 5) ? 4'b0001 : 4'b0000)) begin
        failures++;
        $display("FAIL loadwr_xfer%0d got gnt=%b exp=%b", t, gnt, (t < 5) ? 4'b0001 : 4'b0000);
      end
    end
    xfer_done = 1'b0;
    req = 4'b0000;
    tick();
    $display("test_load_cycle_write: load used old weight 5");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    req = 4'b0000;
    xfer_done = 1'b0;
    cfg_we = 1'b0;
    cfg_idx = 2'd0;
    cfg_wgt = 4'd0;
    test_reset();
    test_round_robin();
    test_weighted();
    test_abandon();
    test_zero_weight();
    test_reset_mid_grant();
    test_cfg_active();
    test_load_cycle_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wrr_arbiter_ctrl.md
WRR_ARBITER_CTRL -- requirements
Module: wrr_arbiter_ctrl

Interface
REQ-001 Parameter NREQ, default 4: number of requesters; only 4 is supported.
REQ-002 Parameter WGT_W, default 4: width of each weight and credit field.
REQ-003 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port req, input, NREQ: level request per requester; bit i belongs to requester i.
REQ-006 Port xfer_done, input, 1: one-cycle pulse from the shared resource marking completion of one transfer by the current grantee.
REQ-007 Port cfg_we, input, 1: weight write strobe.
REQ-008 Port cfg_idx, input, 2: index of the weight being written.
REQ-009 Port cfg_wgt, input, WGT_W: weight value being written.
REQ-010 Port gnt, output, NREQ: registered one-hot grant; all zero when nothing is granted.
REQ-011 Port gnt_id, output, 2: registered binary index of the grantee; valid only while gnt is nonzero.
REQ-012 Port busy, output, 1: registered; high whenever the state is not IDLE.

Function
REQ-013 The block SHALL run a three-state FSM: IDLE, GRANT and GAP.
- IDLE: gnt=0.
- GRANT: gnt=onehot(gnt_id).
- GAP: one turnaround cycle with gnt=0.
REQ-014 In IDLE or GAP with req!=0, the block SHALL select a winner by rotating priority, starting at (last_id+1) mod 4.
- It SHALL enter GRANT next cycle: one cycle of latency from a sampled req to gnt.
REQ-015 In IDLE with req=0, the block SHALL stay in IDLE. In GAP with req=0, it SHALL go to IDLE.
REQ-016 On entering GRANT, the block SHALL:
- set last_id to the winner;
- load credit with weight[winner];
- treat a weight of 0 as 1.
REQ-017 In GRANT, a xfer_done with credit==1 SHALL release the grant: next state GAP.
REQ-018 In GRANT, a xfer_done with credit>1 SHALL decrement credit.
- If req[gnt_id] is low in that same cycle, the grant is released (GAP).
- Otherwise the grant is held.
REQ-019 In GRANT, req[gnt_id] low with xfer_done low SHALL release the grant (abandon): next state GAP, credit unchanged.
REQ-020 Requests from non-granted requesters SHALL NOT affect gnt while in GRANT.
REQ-021 A cfg_we write SHALL update weight[cfg_idx] on the next edge.
- It takes effect only at the next credit load.
- A write to the active grantee's index SHALL NOT alter the running credit.
REQ-022 cfg_we SHALL be accepted in every state, including the cycle that loads credit; the load uses the old weight.
REQ-023 The credit counter SHALL never wrap: it holds at 1 until a release occurs.
REQ-024 xfer_done in IDLE or GAP SHALL be ignored.

Reset
REQ-025 On rst high at a clock edge, the block SHALL set:
- state=IDLE, gnt=0, gnt_id=0, busy=0;
- credit=0;
- last_id=3, so requester 0 has first priority;
- all weights=1, giving pure round robin.
REQ-026 Reset asserted mid-grant SHALL drop gnt in the cycle after the reset edge, with no GAP cycle.
REQ-027 Reset SHALL take priority over cfg_we in the same cycle.

Structure
REQ-028 Shared package arb_pkg SHALL hold:
- NREQ and WGT_W defaults;
- the FSM state enum {IDLE, GRANT, GAP};
- the weight array type.
REQ-029 The rotating-priority selection SHALL be a combinational sub-module, rr_pick, with these ports:
- inputs req[3:0] and last_id[1:0];
- outputs valid and id[1:0].

Verification
REQ-030 Reset, then req=4'b1111 held with no writes -> grants 0, 1, 2, 3, 0 in order, each followed by one GAP cycle, one xfer_done per grant.
REQ-031 Write weight[2]=3 and weight[0]=1, then req=4'b0101 held with continuous xfer_done -> req 2 granted for 3 transfers and req 0 for 1, repeating; grant order 0, 2, 0, 2.
REQ-032 req=4'b0010 pulsed for one cycle -> gnt=4'b0010 one cycle later; next cycle GAP (abandon); then IDLE, busy=0.
REQ-033 Weight 0 written to index 1, req=4'b0010 held -> grant released after a single xfer_done.
REQ-034 rst asserted during GRANT with gnt=4'b0100 -> gnt=0 and busy=0 next cycle; weights back to 1, and the next grant for req=4'b1111 goes to 0.
REQ-035 cfg_we to the active grantee's index (weight 5, running credit 2) -> release after 2 transfers; weight 5 applied on the next grant.
